// File: rtl/wave_trace_pkg.sv
// Shared constants, write-FSM state type and the peak-to-peak level helper
// for the waveform trace generator.
package wave_trace_pkg;
  localparam int H_PIXELS = 1280;
  localparam int V_PIXELS = 1024;
  localparam int SAMPLE_W = 12;
  localparam int TRACE_W  = 10;
  localparam int ADDR_W   = 11;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } wr_state_t;

  // Top four bits of the capture's peak-to-peak swing.
  function automatic logic [3:0] calc_level(input logic [TRACE_W-1:0] max_v,
                                            input logic [TRACE_W-1:0] min_v);
    logic [TRACE_W-1:0] diff;
    diff = max_v - min_v;
    return diff[TRACE_W-1 -: 4];
  endfunction
endpackage

// File: rtl/wave_bank_ram.sv
// Double-buffered trace store: one write port, one registered read port,
// bank picked by the outer index so it maps onto block RAM.
module wave_bank_ram
  import wave_trace_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic               wr_bank,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [TRACE_W-1:0] wr_data,
  input  logic               re,
  input  logic               rd_bank,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [TRACE_W-1:0] rd_data
);
  logic [TRACE_W-1:0] mem [2][H_PIXELS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_bank][rd_addr];
  end
endmodule

// File: rtl/wave_trace_gen.sv
// Captures microphone samples into a ping-pong trace buffer and flags pixels
// lying on the displayed waveform, two clocks after the coordinates arrive.
module wave_trace_gen
  import wave_trace_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                sample_strobe,
  input  logic [SAMPLE_W-1:0] mic_sample,
  input  logic                freeze,
  input  logic [11:0]         VGA_HORZ_COORD,
  input  logic [11:0]         VGA_VERT_COORD,
  output logic                wave_cond,
  output logic [3:0]          level,
  output logic                frame_swap,
  output wr_state_t           dbg_wr_state
);
  // Handshake: sample_strobe is a one-cycle valid for mic_sample with no ready;
  // a strobe is consumed only in FILL with freeze low, otherwise it is dropped.
  wr_state_t          state, state_nxt;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               wr_bank, disp_bank, disp_valid;
  logic [TRACE_W-1:0] max_q, min_q, samp;
  logic               wr_en, swap, last_write;
  logic               coord_zero, prev_zero, frame_start;

  assign samp        = mic_sample[SAMPLE_W-1 -: TRACE_W];
  assign coord_zero  = (VGA_HORZ_COORD == '0) && (VGA_VERT_COORD == '0);
  assign frame_start = coord_zero && !prev_zero;
  assign last_write  = (wr_ptr == ADDR_W'(H_PIXELS - 1));
  assign dbg_wr_state = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (wr_en && last_write) state_nxt = READY;
      READY:   if (swap) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    wr_en = (state == FILL) && sample_strobe && !freeze;
    swap  = (state == READY) && frame_start && !freeze;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      wr_bank    <= 1'b0;
      disp_bank  <= 1'b0;
      disp_valid <= 1'b0;
      max_q      <= '0;
      min_q      <= '1;
      level      <= '0;
      frame_swap <= 1'b0;
      prev_zero  <= 1'b0;
    end else begin
      prev_zero  <= coord_zero;
      frame_swap <= swap;
      if (wr_en) begin
        wr_ptr <= last_write ? '0 : wr_ptr + ADDR_W'(1);
        if (samp > max_q) max_q <= samp;
        if (samp < min_q) min_q <= samp;
      end
      if (swap) begin
        disp_bank  <= wr_bank;
        wr_bank    <= ~wr_bank;
        disp_valid <= 1'b1;
        level      <= calc_level(max_q, min_q);
        max_q      <= '0;
        min_q      <= '1;
      end
    end
  end

  // Read side: stage 0 address, stage 1 RAM data, stage 2 wave_cond.
  logic               h_in0, v_in0;
  logic [TRACE_W-1:0] rd_data, hold_data, prev_hold, prev_data;
  logic               s1_h_in, s1_v_in;
  logic [ADDR_W-1:0]  s1_x, hold_x;
  logic [10:0]        s1_y, y_cur, y_prev, y_lo, y_hi;

  assign h_in0 = VGA_HORZ_COORD < 12'(H_PIXELS);
  assign v_in0 = VGA_VERT_COORD < 12'(V_PIXELS);

  wave_bank_ram u_ram (
    .clk     (CLK),
    .we      (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_ptr),
    .wr_data (samp),
    .re      (h_in0),
    .rd_bank (disp_bank),
    .rd_addr (VGA_HORZ_COORD[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // prev follows the last distinct x; a repeated x keeps the value before it.
  assign prev_data = (s1_x == '0)     ? rd_data :
                     (hold_x == s1_x) ? prev_hold : hold_data;
  assign y_cur  = 11'(V_PIXELS - 1) - 11'(rd_data);
  assign y_prev = 11'(V_PIXELS - 1) - 11'(prev_data);
  assign y_lo   = (y_prev < y_cur) ? y_prev : y_cur;
  assign y_hi   = (y_prev < y_cur) ? y_cur : y_prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_h_in   <= 1'b0;
      s1_v_in   <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      hold_x    <= '0;
      hold_data <= '0;
      prev_hold <= '0;
      wave_cond <= 1'b0;
    end else begin
      s1_h_in <= h_in0;
      s1_v_in <= v_in0;
      s1_x    <= VGA_HORZ_COORD[ADDR_W-1:0];
      s1_y    <= VGA_VERT_COORD[10:0];
      if (s1_h_in) begin
        hold_data <= rd_data;
        if (s1_x != hold_x) begin
          prev_hold <= hold_data;
          hold_x    <= s1_x;
        end
      end
      wave_cond <= disp_valid && s1_h_in && s1_v_in && (s1_y >= y_lo) && (s1_y <= y_hi);
    end
  end
endmodule
